// File: rtl/out_port_ctrl_if.sv
// Bus-side and device-side signal bundle for out_port_ctrl.
// OUT_PORT_PARITY_EN adds the out_parity signal.
interface out_port_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] BusMuxOut;
    logic              OutPortin;
    logic [DATA_W-1:0] OutPort_D;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              ovf_clr;
`ifdef OUT_PORT_PARITY_EN
    logic              out_parity;

    modport master (
        output BusMuxOut, OutPortin, out_ready, ovf_clr,
        input  OutPort_D, out_data, out_valid, full, count, overflow, out_parity
    );
    modport slave (
        input  BusMuxOut, OutPortin, out_ready, ovf_clr,
        output OutPort_D, out_data, out_valid, full, count, overflow, out_parity
    );
`else
    modport master (
        output BusMuxOut, OutPortin, out_ready, ovf_clr,
        input  OutPort_D, out_data, out_valid, full, count, overflow
    );
    modport slave (
        input  BusMuxOut, OutPortin, out_ready, ovf_clr,
        output OutPort_D, out_data, out_valid, full, count, overflow
    );
`endif
endinterface

// File: rtl/out_port_ctrl.sv
// Output-port controller: OutPort register, DEPTH-entry FIFO and a valid/ready output stage.
// Optional feature macro: OUT_PORT_PARITY_EN (adds registered even parity of out_data).
module out_port_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input logic            clk,
    input logic            reset,
    out_port_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    state_t            state_r, state_nxt_s;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r, count_nxt_s;
    logic              full_r, overflow_r, out_valid_r;
    logic [DATA_W-1:0] out_data_r, outport_r;
    logic              push_s, drop_s, pop_s;

    assign push_s = bus.OutPortin & ~full_r;
    assign drop_s = bus.OutPortin &  full_r;

    // Output-stage next state and pop decision; pop only sees words already in the FIFO.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (count_r != {CNT_W{1'b0}}) begin
                    pop_s       = 1'b1;
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (count_r != {CNT_W{1'b0}}) begin
                        pop_s       = 1'b1;
                        state_nxt_s = SEND;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                pop_s       = 1'b0;
            end
        endcase
    end

    // Occupancy after this edge; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FIFO storage, pointers, occupancy flags and the architectural OutPort register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= {DATA_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
            outport_r  <= {DATA_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= bus.BusMuxOut;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
                outport_r       <= bus.BusMuxOut;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_W'(DEPTH));
            // A drop on the same edge as ovf_clr keeps the flag set.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (bus.ovf_clr) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Output stage register: out_data holds its last word when the stage empties.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
        end else begin
            out_valid_r <= (state_nxt_s == SEND);
            if (pop_s) begin
                out_data_r <= mem_r[rd_ptr_r];
            end
        end
    end

`ifdef OUT_PORT_PARITY_EN
    logic out_parity_r;

    // Parity is registered with the same pop that loads out_data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_parity_r <= 1'b0;
        end else if (pop_s) begin
            out_parity_r <= even_parity(mem_r[rd_ptr_r]);
        end
    end

    assign bus.out_parity = out_parity_r;
`endif

    assign bus.OutPort_D = outport_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.full      = full_r;
    assign bus.count     = count_r;
    assign bus.overflow  = overflow_r;
endmodule
